ne_seq_ctrl: RTL and testbench
==============================

Name: ne_seq_ctrl

Overview:
Sequencer for the nonlinear-energy feature datapath (ne_comp_unit, accumulator, 5-stage window shifter and 5-input adder).
- Accepts a sample stream from the acquisition buffer via a valid/ready handshake and feeds one sample per enable pulse into the datapath.
- Counts samples per window and windows per feature, then captures the summed feature when the datapath flags valid.
- Compares the feature against a programmable threshold and presents the result downstream with valid/ready backpressure.

Parameters:
IN_W, 16, sample width (matches datapath input_width)
OUT_W, 40, feature width (matches datapath output_width)
WIN_LEN, 50, samples per accumulation window
WIN_NUM, 5, windows summed per feature (shifter depth)
TIMEOUT, 64, max cycles to wait for ne_data_valid

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: clear datapath and begin streaming
stop  in  1  one-cycle pulse: return to idle
thresh  in  OUT_W  signed detection threshold, sampled at capture
s_valid  in  1  upstream sample valid
s_ready  out  1  controller accepts sample
s_data  in  IN_W  signed sample
ne_din  out  IN_W  registered sample to datapath din
ne_en  out  1  datapath enable, active-low
ne_rst  out  1  datapath reset, active-high
ne_dout  in  OUT_W  signed datapath feature
ne_data_valid  in  1  datapath feature valid
f_valid  out  1  result valid
f_ready  in  1  downstream accepts result
f_data  out  OUT_W  captured feature
f_detect  out  1  f_data > thresh (signed)
busy  out  1  state != IDLE
err  out  1  sticky timeout flag, cleared by rst or start
det_cnt  out  16  detection count (see Optional Feature)

Behaviour:
- Reset values: s_ready=0, ne_din=0, ne_en=1, ne_rst=1, f_valid=0, f_data=0, f_detect=0, busy=0, err=0, det_cnt=0. State = IDLE; samp_cnt=0, win_cnt=0, tmo_cnt=0, stop_pend=0.
- States: IDLE, CLEAR, RUN, WAIT_V, HOLD.
- IDLE:
  - ne_en=1, ne_rst=1, s_ready=0.
  - start -> CLEAR.
  - stop is ignored.
- CLEAR (exactly 1 cycle):
  - ne_rst=1; counters zeroed; err cleared.
  - -> RUN.
- RUN:
  - ne_rst=0, s_ready=1.
  - On s_valid&&s_ready: ne_din<=s_data and ne_en<=0 for exactly the next cycle. Otherwise ne_en<=1. Latency from sample accept to datapath enable is 1 cycle.
  - samp_cnt increments per accepted sample and wraps WIN_LEN-1 -> 0. On wrap, win_cnt increments, saturating at WIN_NUM.
  - If the wrap makes win_cnt reach WIN_NUM, next state is WAIT_V and s_ready drops in the same cycle the transition is registered.
- WAIT_V:
  - s_ready=0, ne_en=1; tmo_cnt increments.
  - ne_data_valid=1: f_data<=ne_dout, f_detect<=(ne_dout>thresh signed), tmo_cnt<=0 -> HOLD.
  - tmo_cnt==TIMEOUT-1 without valid: err<=1 -> IDLE.
- HOLD:
  - f_valid=1; f_data and f_detect are held stable; s_ready=0.
  - On f_ready: f_valid<=0. Then -> IDLE if stop_pend (clearing stop_pend), else -> RUN.
  - win_cnt stays at WIN_NUM, so every later full window produces one result (sliding 5-window sum).
- stop:
  - In RUN: -> IDLE next cycle; any partial window is discarded.
  - In CLEAR, WAIT_V or HOLD: sets stop_pend, applied after the result handshake. A pending result is never dropped.
- start outside IDLE is ignored. start and stop in the same IDLE cycle: start wins.
- rst at any cycle overrides everything and returns all outputs to their reset values next edge.
- Compare: signed OUT_W; equality gives f_detect=0.

Optional Feature:
NE_SEQ_CTRL_STATS_EN
- Defined: det_cnt counts completed handshakes with f_detect=1. It saturates at 16'hFFFF and is cleared by rst and by CLEAR.
- Undefined: det_cnt is tied to 0 and no counter logic is generated.

Test Plan:
1. rst, start, then 250 samples with s_valid held high and ne_data_valid=1 one cycle after the 250th enable -> exactly 250 ne_en low pulses, each 1 cycle after accept. f_valid rises with f_data=ne_dout.
2. thresh=1000, ne_dout=1001 then a later feature of 1000 -> f_detect=1 then 0. Also ne_dout=-5 with thresh=-10 -> f_detect=1.
3. f_ready held low for 20 cycles in HOLD while s_valid=1 -> s_ready=0 throughout, f_data stable, no ne_en pulses. After f_ready, a further 50 samples produce a second result.
4. ne_data_valid never asserted in WAIT_V -> err=1 after TIMEOUT=64 cycles, state IDLE, busy=0. A following start clears err.
5. stop at sample 120 in RUN -> IDLE next cycle, s_ready=0. stop during HOLD -> result still delivered, then IDLE.
6. With NE_SEQ_CTRL_STATS_EN: 3 detecting results plus 1 non-detecting -> det_cnt=3. rst mid-RUN -> det_cnt=0 and all outputs at reset values.

Source files
------------

// File: rtl/ne_seq_ctrl_if.sv
// Valid/ready stream bundle for the ne_seq_ctrl sample input and feature output.
// W sets the payload width; the master drives valid/data and the slave drives ready.
interface ne_seq_ctrl_if #(
  parameter int W = 16
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/ne_seq_ctrl.sv
// Sequencer for the nonlinear-energy datapath: streams samples, captures features.
// Optional detection counter enabled by defining NE_SEQ_CTRL_STATS_EN.
module ne_seq_ctrl #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 40,
  parameter int WIN_LEN = 50,
  parameter int WIN_NUM = 5,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [OUT_W-1:0]   thresh,
  ne_seq_ctrl_if.slave       s,
  output logic [IN_W-1:0]    ne_din,
  output logic               ne_en,
  output logic               ne_rst,
  input  logic [OUT_W-1:0]   ne_dout,
  input  logic               ne_data_valid,
  ne_seq_ctrl_if.master      f,
  output logic               f_detect,
  output logic               busy,
  output logic               err,
  output logic [15:0]        det_cnt
);

  localparam int SC_W = $clog2(WIN_LEN);
  localparam int WC_W = $clog2(WIN_NUM + 1);
  localparam int TC_W = $clog2(TIMEOUT + 1);

  localparam logic [SC_W-1:0] SAMP_LAST = SC_W'(WIN_LEN - 1);
  localparam logic [WC_W-1:0] WIN_MAX   = WC_W'(WIN_NUM);
  localparam logic [WC_W-1:0] WIN_PEN   = WC_W'(WIN_NUM - 1);
  localparam logic [TC_W-1:0] TMO_LAST  = TC_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    WAIT_V,
    HOLD
  } state_t;

  state_t          state;
  logic [SC_W-1:0] samp_cnt;
  logic [WC_W-1:0] win_cnt;
  logic [TC_W-1:0] tmo_cnt;
  logic            stop_pend;
  logic            take;
  logic            wrap;

  assign take = s.valid && s.ready;
  assign wrap = take && (samp_cnt == SAMP_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      samp_cnt  <= '0;
      win_cnt   <= '0;
      tmo_cnt   <= '0;
      stop_pend <= 1'b0;
      s.ready   <= 1'b0;
      ne_din    <= '0;
      ne_en     <= 1'b1;
      ne_rst    <= 1'b1;
      f.valid   <= 1'b0;
      f.data    <= '0;
      f_detect  <= 1'b0;
      err       <= 1'b0;
    end else begin
      ne_en <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            err   <= 1'b0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          samp_cnt <= '0;
          win_cnt  <= '0;
          tmo_cnt  <= '0;
          if (stop) stop_pend <= 1'b1;
          ne_rst  <= 1'b0;
          s.ready <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (stop) begin
            stop_pend <= 1'b0;
            s.ready   <= 1'b0;
            ne_rst    <= 1'b1;
            state     <= IDLE;
          end else if (take) begin
            ne_din   <= s.data;
            ne_en    <= 1'b0;
            samp_cnt <= wrap ? '0 : samp_cnt + 1'b1;
            if (wrap) begin
              if (win_cnt != WIN_MAX) win_cnt <= win_cnt + 1'b1;
              // Once the shifter is full every window closes a feature.
              if (win_cnt >= WIN_PEN) begin
                s.ready <= 1'b0;
                tmo_cnt <= '0;
                state   <= WAIT_V;
              end
            end
          end
        end
        WAIT_V: begin
          if (stop) stop_pend <= 1'b1;
          if (ne_data_valid) begin
            f.data   <= ne_dout;
            f_detect <= $signed(ne_dout) > $signed(thresh);
            f.valid  <= 1'b1;
            tmo_cnt  <= '0;
            state    <= HOLD;
          end else if (tmo_cnt == TMO_LAST) begin
            err       <= 1'b1;
            tmo_cnt   <= '0;
            stop_pend <= 1'b0;
            ne_rst    <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (stop) stop_pend <= 1'b1;
          if (f.ready) begin
            f.valid <= 1'b0;
            if (stop_pend || stop) begin
              stop_pend <= 1'b0;
              ne_rst    <= 1'b1;
              state     <= IDLE;
            end else begin
              s.ready <= 1'b1;
              state   <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NE_SEQ_CTRL_STATS_EN
  logic hs;
  assign hs = f.valid && f.ready;

  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      det_cnt <= '0;
    end else if (hs && f_detect && det_cnt != 16'hFFFF) begin
      det_cnt <= det_cnt + 1'b1;
    end
  end
`else
  assign det_cnt = '0;
`endif

endmodule

// File: tb/tb_ne_seq_ctrl.sv
// Bench for ne_seq_ctrl: transaction-level model plus directed scenarios.
// Build with NE_SEQ_CTRL_STATS_EN defined to exercise the detection counter.
module tb_ne_seq_ctrl;
  localparam int IN_W    = 16;
  localparam int OUT_W   = 40;
  localparam int WIN_LEN = 50;
  localparam int WIN_NUM = 5;
  localparam int TIMEOUT = 64;
`ifdef NE_SEQ_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, stop, ne_data_valid;
  logic [OUT_W-1:0] thresh, ne_dout;
  logic [IN_W-1:0]  ne_din;
  logic             ne_en, ne_rst, f_detect, busy, err;
  logic [15:0]      det_cnt;

  ne_seq_ctrl_if #(.W(IN_W))  s_if ();
  ne_seq_ctrl_if #(.W(OUT_W)) f_if ();

  ne_seq_ctrl #(
    .IN_W(IN_W), .OUT_W(OUT_W), .WIN_LEN(WIN_LEN),
    .WIN_NUM(WIN_NUM), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .thresh(thresh), .s(s_if), .ne_din(ne_din),
    .ne_en(ne_en), .ne_rst(ne_rst), .ne_dout(ne_dout),
    .ne_data_valid(ne_data_valid), .f(f_if),
    .f_detect(f_detect), .busy(busy), .err(err),
    .det_cnt(det_cnt)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int en_pulses = 0;
  bit chk_on    = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Model: tracks total samples since start; a feature is due whenever
  // the total reaches a multiple of WIN_LEN at or beyond a full shifter.
  typedef enum {M_OFF, M_CLR, M_RUN, M_WAIT, M_SHOW} mode_t;
  mode_t            mode;
  int               tot, wt;
  bit               pend, take;
  logic             e_sr, e_en, e_nrst, e_fv, e_det, e_err;
  logic [IN_W-1:0]  e_din;
  logic [OUT_W-1:0] e_fd;
  logic [15:0]      e_cnt;

  always @(posedge clk) begin
    if (rst) begin
      mode = M_OFF; tot = 0; wt = 0; pend = 1'b0;
      e_sr = 1'b0; e_en = 1'b1; e_nrst = 1'b1; e_fv = 1'b0;
      e_det = 1'b0; e_err = 1'b0; e_din = '0; e_fd = '0; e_cnt = '0;
    end else begin
      take = s_if.valid && e_sr;
      e_en = 1'b1;
      case (mode)
        M_OFF: if (start) begin mode = M_CLR; e_err = 1'b0; end
        M_CLR: begin
          if (stop) pend = 1'b1;
          tot = 0; e_cnt = '0; e_nrst = 1'b0; e_sr = 1'b1; mode = M_RUN;
        end
        M_RUN: begin
          if (stop) begin
            mode = M_OFF; e_sr = 1'b0; e_nrst = 1'b1; pend = 1'b0;
          end else if (take) begin
            e_en = 1'b0; e_din = s_if.data; tot++;
            if (tot >= WIN_LEN * WIN_NUM && tot % WIN_LEN == 0) begin
              mode = M_WAIT; e_sr = 1'b0; wt = 0;
            end
          end
        end
        M_WAIT: begin
          if (stop) pend = 1'b1;
          if (ne_data_valid) begin
            e_fv = 1'b1; e_fd = ne_dout; mode = M_SHOW;
            e_det = $signed(ne_dout) > $signed(thresh);
          end else begin
            wt++;
            if (wt == TIMEOUT) begin
              e_err = 1'b1; e_nrst = 1'b1; pend = 1'b0; mode = M_OFF;
            end
          end
        end
        M_SHOW: begin
          if (stop) pend = 1'b1;
          if (f_if.ready) begin
            e_fv = 1'b0;
            if (STATS && e_det && e_cnt != 16'hFFFF) e_cnt++;
            if (pend) begin
              pend = 1'b0; e_nrst = 1'b1; mode = M_OFF;
            end else begin
              e_sr = 1'b1; mode = M_RUN;
            end
          end
        end
        default: mode = M_OFF;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cycle_outputs",
          {s_if.ready, ne_din, ne_en, ne_rst, f_if.valid, f_if.data,
           f_detect, busy, err, det_cnt},
          {e_sr, e_din, e_en, e_nrst, e_fv, e_fd,
           e_det, mode != M_OFF, e_err, e_cnt});
      if (!ne_en) en_pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  task automatic ack();
    f_if.ready = 1'b1; cyc(1); f_if.ready = 1'b0;
  endtask

  task automatic stream(input int n);
    int seen = 0;
    int t = 0;
    s_if.valid = 1'b1;
    while (seen < n && t < 2 * n + 50) begin
      s_if.data = IN_W'(t * 97 + 13);
      cyc(1);
      t++;
      if (!ne_en) seen++;
    end
    s_if.valid = 1'b0;
    chk("stream_pulses", seen, n);
  endtask

  task automatic deliver(input int val);
    int t = 0;
    cyc(1);
    ne_dout = OUT_W'(val);
    ne_data_valid = 1'b1;
    cyc(1);
    ne_data_valid = 1'b0;
    while (!f_if.valid && t < 10) begin cyc(1); t++; end
    chk("result_valid", f_if.valid, 1'b1);
  endtask

  localparam logic [78:0] RST_VEC =
    {1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 40'h0, 1'b0, 1'b0, 1'b0, 16'h0};

  initial begin
    int p0;
    int bad;
    int k;
    rst = 1'b1; start = 1'b0; stop = 1'b0; thresh = '0;
    ne_dout = '0; ne_data_valid = 1'b0;
    s_if.valid = 1'b0; s_if.data = '0; f_if.ready = 1'b0;
    cyc(2);
    chk_on = 1'b1;
    chk("reset_state",
        {s_if.ready, ne_din, ne_en, ne_rst, f_if.valid, f_if.data,
         f_detect, busy, err, det_cnt}, RST_VEC);
    rst = 1'b0;
    pulse_stop();
    chk("idle_stop_ignored", busy, 1'b0);

    // Full first feature of 5 windows
    thresh = OUT_W'(1000);
    p0 = en_pulses;
    pulse_start();
    stream(250);
    deliver(1001);
    chk("f_data_1001", f_if.data, 40'd1001);
    chk("detect_above", f_detect, 1'b1);
    ack();
    cyc(3);
    chk("first_pulse_count", en_pulses - p0, 250);

    // Sliding window results and signed compare
    stream(50);
    deliver(1000);
    chk("detect_equal", f_detect, 1'b0);
    ack();
    thresh = OUT_W'(-10);
    stream(50);
    deliver(-5);
    chk("f_data_neg5", f_if.data, 40'hFF_FFFF_FFFB);
    chk("detect_signed", f_detect, 1'b1);

    // Backpressure in HOLD
    s_if.valid = 1'b1;
    bad = 0;
    repeat (20) begin
      cyc(1);
      if (s_if.ready) bad++;
      if (!ne_en) bad++;
      if (!f_if.valid) bad++;
      if (f_if.data !== 40'hFF_FFFF_FFFB) bad++;
    end
    chk("hold_stall", bad, 0);
    s_if.valid = 1'b0;
    ack();

    // Stop during HOLD still delivers
    thresh = OUT_W'(20000);
    stream(50);
    deliver(30000);
    chk("detect_30000", f_detect, 1'b1);
    pulse_stop();
    cyc(3);
    chk("hold_after_stop", f_if.valid, 1'b1);
    ack();
    chk("idle_after_stop", {busy, f_if.valid}, 2'b00);
    cyc(1);
    chk("det_cnt_three", det_cnt, STATS ? 16'd3 : 16'd0);

    // Start and stop together, then stop mid-RUN
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    chk("start_wins", busy, 1'b1);
    stream(120);
    pulse_stop();
    chk("stop_in_run", {busy, s_if.ready, ne_rst}, 3'b001);

    // Timeout waiting for the datapath
    pulse_start();
    stream(250);
    k = 0;
    while (!err && k < 100) begin cyc(1); k++; end
    chk("timeout_cycles", k, TIMEOUT);
    chk("timeout_idle", {err, busy}, 2'b10);
    pulse_start();
    chk("err_cleared", {err, busy}, 2'b01);

    // Reset in the middle of RUN
    thresh = OUT_W'(1000);
    stream(250);
    deliver(5000);
    ack();
    stream(20);
    chk("det_cnt_one", det_cnt, STATS ? 16'd1 : 16'd0);
    s_if.valid = 1'b1;
    rst = 1'b1;
    cyc(1);
    chk("mid_run_reset",
        {s_if.ready, ne_din, ne_en, ne_rst, f_if.valid, f_if.data,
         f_detect, busy, err, det_cnt}, RST_VEC);
    rst = 1'b0;
    s_if.valid = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
